// File: rtl/dmem_sched_pkg.sv
// Shared types and default widths for the data-RAM readout scheduler.
//   sched_state_t  : readout engine FSM states
//   readout_word_t : {addr, data} word streamed to the host dump path
package dmem_sched_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 48;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } readout_word_t;

endpackage

// File: rtl/dmem_port_mux.sv
// RAM port selection between the core and the readout engine.
//   eng_issue   : engine owns the port this cycle (read of eng_addr)
//   core_*      : core request, forwarded whenever the engine is not issuing
//   mem_*_c     : combinational RAM port controls
module dmem_port_mux #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 48
) (
  input  logic              eng_issue,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [ADDR_W-1:0] mem_addr_c,
  output logic [DATA_W-1:0] mem_wdata_c,
  output logic              mem_we_c
);

  // Idle port is driven to zero so nothing is written by accident.
  always_comb begin
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_we_c    = 1'b0;
    if (eng_issue) begin
      mem_addr_c = eng_addr;
    end else if (core_req) begin
      mem_addr_c  = core_addr;
      mem_wdata_c = core_wdata;
      mem_we_c    = core_we;
    end
  end

endmodule

// File: rtl/dmem_readout_sched.sv
// Shares the single-port data RAM between the core load/store port and a
// readout engine that scans [base_addr, base_addr+word_count) and streams
// {addr, data} words over valid/ready. The core always wins the port.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   core_req/we/addr/wdata     : core RAM request; core_rdata = mem_rdata
//   mem_addr/wdata/we, mem_rdata : RAM port (read data one cycle late)
//   start, base_addr, word_count : readout launch (accepted only in IDLE)
//   busy, done                 : engine status, done is a one-cycle pulse
//   out_data, out_valid, out_ready : {addr, data} output stream
// Build option DUMP_SKIP_ZERO_EN: words whose data is zero are not emitted.
module dmem_readout_sched
  import dmem_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     core_req,
  input  logic                     core_we,
  input  logic [ADDR_W-1:0]        core_addr,
  input  logic [DATA_W-1:0]        core_wdata,
  output logic [DATA_W-1:0]        core_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [CNT_W-1:0]         word_count,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W+DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  sched_state_t              state_q, state_d;
  logic [ADDR_W-1:0]         cur_q, cur_d;
  logic [CNT_W-1:0]          rem_q, rem_d;
  logic [ADDR_W+DATA_W-1:0]  out_q, out_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      valid_q, valid_d;
  logic                      eng_issue;

  assign core_rdata = mem_rdata;
  assign busy       = busy_q;
  assign done       = done_q;
  assign out_valid  = valid_q;
  assign out_data   = out_q;

  dmem_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .eng_issue   (eng_issue),
    .eng_addr    (cur_q),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .mem_addr_c  (mem_addr),
    .mem_wdata_c (mem_wdata),
    .mem_we_c    (mem_we)
  );

  // Next-state, engine issue and datapath updates.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rem_d     = rem_q;
    out_d     = out_q;
    eng_issue = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = base_addr;
          rem_d   = word_count;
          state_d = (word_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        // Engine only reads in cycles the core leaves free.
        if (!core_req) begin
          eng_issue = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // mem_rdata here answers last cycle's engine read of cur_q.
        cur_d = cur_q + ADDR_W'(1);
        rem_d = rem_q - CNT_W'(1);
`ifdef DUMP_SKIP_ZERO_EN
        if (mem_rdata == '0) begin
          state_d = (rem_q == CNT_W'(1)) ? DONE : ISSUE;
        end else begin
          out_d   = {cur_q, mem_rdata};
          state_d = HOLD;
        end
`else
        out_d   = {cur_q, mem_rdata};
        state_d = HOLD;
`endif
      end
      HOLD: begin
        if (out_ready) begin
          state_d = (rem_q == '0) ? DONE : ISSUE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d == ISSUE) || (state_d == WAIT) || (state_d == HOLD);
    done_d  = (state_d == DONE);
    valid_d = (state_d == HOLD);
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_dmem_readout_sched.sv
// Directed bench for dmem_readout_sched with a small one-cycle-latency RAM
// model (low 8 address bits). Inputs are driven and outputs sampled on the
// falling edge.
module tb_dmem_readout_sched;
  import dmem_sched_pkg::*;

  logic        clk;
  logic        reset;
  logic        core_req;
  logic        core_we;
  logic [15:0] core_addr;
  logic [47:0] core_wdata;
  logic [47:0] core_rdata;
  logic [15:0] mem_addr;
  logic [47:0] mem_wdata;
  logic        mem_we;
  logic [47:0] mem_rdata;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int n_chk;
  int n_fail;

  bit [47:0] mem [0:255];
  bit [47:0] rd_q;

  dmem_readout_sched dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    rd_q <= mem[mem_addr[7:0]];
  end
  assign mem_rdata = rd_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word(input logic [15:0] a, input logic [47:0] d);
    readout_word_t r;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic core_write(input logic [15:0] a, input logic [47:0] d);
    core_req = 1'b1; core_we = 1'b1; core_addr = a; core_wdata = d;
    cyc();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
  endtask

  task automatic launch(input logic [15:0] b, input logic [15:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    start = 0; base_addr = '0; word_count = '0; out_ready = 1'b1;
    cyc(); cyc();
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  out_data, 64'd0);
    check("rst_we",    64'(mem_we), 64'd0);
    check("rst_addr",  64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;

    core_write(16'h0010, 48'hA);
    core_write(16'h0011, 48'hB);
    core_write(16'h0012, 48'hC);

    // Basic run, no contention.
    launch(16'h0010, 16'd3);                        // now cycle 1
    check("t1_addr",  64'(mem_addr), 64'h10);
    check("t1_we",    64'(mem_we), 64'd0);
    check("t1_busy",  64'(busy), 64'd1);
    check("t1_nvld",  64'(out_valid), 64'd0);
    cyc();                                          // cycle 2
    check("t1_rdata", 64'(core_rdata), 64'hA);
    cyc();                                          // cycle 3
    check("t1_vld0",  64'(out_valid), 64'd1);
    check("t1_w0",    out_data, word(16'h0010, 48'hA));
    cyc(); cyc(); cyc();                            // cycle 6
    check("t1_w1",    out_data, word(16'h0011, 48'hB));
    cyc(); cyc(); cyc();                            // cycle 9
    check("t1_w2",    out_data, word(16'h0012, 48'hC));
    check("t1_ndone", 64'(done), 64'd0);
    cyc();                                          // cycle 10
    check("t1_done",  64'(done), 64'd1);
    check("t1_idle",  64'(busy), 64'd0);
    cyc();
    check("t1_dpls",  64'(done), 64'd0);

    // Core writes 0x77 to 0x0011 for 4 cycles while engine is in ISSUE.
    launch(16'h0010, 16'd3);                        // cycle 1
    core_req = 1'b1; core_we = 1'b1; core_addr = 16'h0011; core_wdata = 48'h77;
    #1;
    check("t2_maddr", 64'(mem_addr), 64'h11);
    check("t2_mwe",   64'(mem_we), 64'd1);
    check("t2_mwd",   64'(mem_wdata), 64'h77);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 1) check("t2_stall", 64'(out_valid), 64'd0);
    end
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;   // cycle 5
    cyc(); cyc();                                   // cycle 7
    check("t2_vld0",  64'(out_valid), 64'd1);
    check("t2_w0",    out_data, word(16'h0010, 48'hA));
    cyc(); cyc(); cyc();
    check("t2_w1",    out_data, word(16'h0011, 48'h77));
    cyc(); cyc(); cyc();
    check("t2_w2",    out_data, word(16'h0012, 48'hC));
    cyc();
    check("t2_done",  64'(done), 64'd1);
    cyc();

    // Backpressure: output held, no RAM traffic.
    out_ready = 1'b0;
    launch(16'h0012, 16'd1);
    cyc(); cyc();                                   // cycle 3
    for (int k = 0; k < 5; k++) begin
      check("t3_vld",  64'(out_valid), 64'd1);
      check("t3_hold", out_data, word(16'h0012, 48'hC));
      check("t3_we",   64'(mem_we), 64'd0);
      check("t3_addr", 64'(mem_addr), 64'd0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    check("t3_done",  64'(done), 64'd1);
    cyc();

    // Address wrap, plus a start while busy that must be ignored.
    core_write(16'hFFFF, 48'h1234);
    core_write(16'h0000, 48'h5678);
    launch(16'hFFFF, 16'd2);                        // cycle 1
    start = 1'b1; base_addr = 16'h0040; word_count = 16'd5;
    cyc();                                          // cycle 2
    start = 1'b0;
    cyc();                                          // cycle 3
    check("t4_w0",    out_data, word(16'hFFFF, 48'h1234));
    cyc(); cyc(); cyc();
    check("t4_w1",    out_data, word(16'h0000, 48'h5678));
    cyc();
    check("t4_done",  64'(done), 64'd1);
    cyc();
    check("t4_idle",  64'(busy), 64'd0);
    check("t4_nvld",  64'(out_valid), 64'd0);

    // Zero count: done at cycle 1 without a read.
    launch(16'h0020, 16'd0);
    check("t5_done",  64'(done), 64'd1);
    check("t5_busy",  64'(busy), 64'd0);
    check("t5_nvld",  64'(out_valid), 64'd0);
    check("t5_we",    64'(mem_we), 64'd0);
    cyc();
    check("t5_dpls",  64'(done), 64'd0);
    check("t5_nvld2", 64'(out_valid), 64'd0);

    // Reset while holding a word.
    out_ready = 1'b0;
    launch(16'h0010, 16'd3);
    cyc(); cyc();                                   // cycle 3, HOLD
    check("t6_vld",   64'(out_valid), 64'd1);
    reset = 1'b1;
    cyc();
    check("t6_nvld",  64'(out_valid), 64'd0);
    check("t6_busy",  64'(busy), 64'd0);
    check("t6_data",  out_data, 64'd0);
    reset = 1'b0; out_ready = 1'b1;
    launch(16'h0012, 16'd1);                        // accepted only from IDLE
    check("t6_rbusy", 64'(busy), 64'd1);
    check("t6_raddr", 64'(mem_addr), 64'h12);
    cyc(); cyc();
    check("t6_w0",    out_data, word(16'h0012, 48'hC));
    cyc();
    check("t6_done",  64'(done), 64'd1);
    cyc();

`ifdef DUMP_SKIP_ZERO_EN
    // Zero words are skipped.
    core_write(16'h0010, 48'h0);
    core_write(16'h0011, 48'h5);
    core_write(16'h0012, 48'h0);
    launch(16'h0010, 16'd3);
    cyc(); cyc();                                   // cycle 3
    check("t7_skip0", 64'(out_valid), 64'd0);
    cyc(); cyc();                                   // cycle 5
    check("t7_vld",   64'(out_valid), 64'd1);
    check("t7_w",     out_data, word(16'h0011, 48'h5));
    cyc(); cyc();                                   // cycle 7
    check("t7_skip2", 64'(out_valid), 64'd0);
    cyc();                                          // cycle 8
    check("t7_done",  64'(done), 64'd1);
`else
    // Zero words are emitted.
    core_write(16'h0010, 48'h0);
    launch(16'h0010, 16'd1);
    cyc(); cyc();
    check("t7_vld",   64'(out_valid), 64'd1);
    check("t7_w",     out_data, word(16'h0010, 48'h0));
    cyc();
    check("t7_done",  64'(done), 64'd1);
`endif
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_readout_sched.md
# dmem_readout_sched

Scheduler that shares the single-port data RAM between the ASIP core's load/store port and a readout engine. The readout engine walks an address range after a start command and streams `{addr, data}` words to the host/text-dump path over a valid/ready handshake. The core always has priority. The engine only uses RAM cycles in which the core makes no request. The block sits between the `asip` core, the data `RAM` and the top-level `data`/`enable` output.

## Interface
Parameters:
- `ADDR_W`, 16: RAM address width.
- `DATA_W`, 48: RAM word width. The output word width is `ADDR_W+DATA_W` (64).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `core_req`  in  1  core accesses RAM this cycle.
- `core_we`  in  1  write enable, qualified by `core_req`.
- `core_addr`  in  ADDR_W  core address.
- `core_wdata`  in  DATA_W  core write data.
- `core_rdata`  out  DATA_W  equals `mem_rdata` (combinational pass-through).
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_we`  out  1  RAM write enable.
- `mem_rdata`  in  DATA_W  RAM read data, valid 1 cycle after its address.
- `start`  in  1  single-cycle pulse that launches a readout.
- `base_addr`  in  ADDR_W  first address; sampled on `start`.
- `word_count`  in  16  number of addresses to scan; sampled on `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the `DONE` state.
- `done`  out  1  one-cycle pulse when a readout completes.
- `out_data`  out  ADDR_W+DATA_W  `{addr, data}`.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.

## Operation
- States: `IDLE`, `ISSUE`, `WAIT`, `HOLD`, `DONE`.
- `IDLE`:
  - `start` latches `cur=base_addr` and `rem=word_count`.
  - If `word_count==0`, go to `DONE`; otherwise go to `ISSUE`.
  - `start` is ignored in every state other than `IDLE`.
- `ISSUE`:
  - If `core_req=1`: the core owns the RAM. `mem_addr=core_addr`, `mem_we=core_we`, `mem_wdata=core_wdata`. Stay in `ISSUE`.
  - Otherwise: `mem_addr=cur`, `mem_we=0`, go to `WAIT`.
- `WAIT`:
  - Capture `out_data={cur, mem_rdata}`, then `cur<=cur+1` (wraps modulo 2^ADDR_W) and `rem<=rem-1`. Go to `HOLD`.
  - The core may access RAM in this cycle; its request is forwarded. The captured data belongs to the previous cycle's engine read.
- `HOLD`:
  - `out_valid=1`.
  - On `out_ready`: go to `DONE` if `rem==0`, else go to `ISSUE`.
  - `out_data` and `out_valid` are stable until accepted.
- `DONE`: `done=1` for one cycle, `busy=0`, go to `IDLE`.
- In every state except an engine issue in `ISSUE`, the RAM port carries the core request. When `core_req=0` and the engine is not issuing, `mem_we=0`.
- Core writes to addresses not yet scanned are visible to the readout; no coherence beyond that.
- Reset (any state, mid-readout included) returns to `IDLE` and drops any word in flight.

## Timing
- Reset values: `busy=0`, `done=0`, `out_valid=0`, `out_data=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`; `cur` and `rem` are 0.
- No contention, `out_ready=1`: `start` at cycle 0 → `mem_addr=base` at cycle 1 → capture at cycle 2 → `out_valid` at cycle 3. Steady state is one word per 3 cycles.
- Each cycle of `core_req` in `ISSUE` adds one cycle of latency. The core never sees a stall.
- `start` with `word_count==0`: `done` at cycle 1; no RAM read and no `out_valid`.
- `word_count=0xFFFF` is legal and scans 65535 words.

## Configuration
- `DUMP_SKIP_ZERO_EN` defined:
  - In `WAIT`, a word with `mem_rdata==0` is not loaded into the output buffer.
  - `cur` and `rem` still update, and the FSM goes directly to `ISSUE` (or to `DONE` if `rem` reaches 0).
  - This matches the top-level `enable` rule that suppresses zero data.
- Undefined: every scanned word is emitted, including zeros.

## Structure
- Shared package `dmem_sched_pkg` holds:
  - the state enum `sched_state_t`;
  - `ADDR_W` and `DATA_W` default constants;
  - the packed `readout_word_t` `{addr, data}`.
- One sub-module, `dmem_port_mux`: combinational selection of the RAM address, write data and write enable between the core and the engine, driven by an `eng_issue` select.

## Test plan
- `base=0x0010`, `count=3`, RAM[0x10..0x12]=`0xA`,`0xB`,`0xC`, `out_ready=1`, no core traffic → `out_data` `0x0010_..._00000000000A`, then `...0011...B`, then `...0012...C`; first `out_valid` at cycle 3; `done` one cycle after the third accept.
- Same run with `core_req=1`, `core_we=1`, `addr=0x0011`, `wdata=0x77` held for 4 cycles from cycle 1 → RAM write occurs; first word is delayed 4 cycles; the second word reads `0x77`.
- `out_ready=0` for 5 cycles while `out_valid` → `out_data` held constant; no further RAM read issued.
- `base=0xFFFF`, `count=2` → addresses `0xFFFF` then `0x0000` emitted.
- `count=0` → `done` at cycle 1, `out_valid` never asserted. A `start` while `busy` is ignored.
- `reset` asserted in `HOLD` → next cycle `out_valid=0`, `busy=0`, state `IDLE`. With `DUMP_SKIP_ZERO_EN`, RAM[0x10..0x12]=`0,5,0` emits only `{0x0011,5}`.
